// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes request lines, latches pending edges and
// presents one prioritized, masked request to the control unit. Define
// INT_LEVEL_EN to make PENDING follow the synchronized line levels instead.
module int_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               I_SET,
  input  logic               I_CLR,
  input  logic               INT_ACK,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_DIN,
  input  logic [NUM_SRC-1:0] PEND_CLR,
  output logic               INT,
  output logic [ID_W-1:0]    INT_ID,
  output logic               I_FLAG,
  output logic [NUM_SRC-1:0] PENDING
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERV
  } state_t;

  state_t                                  state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]     sync_q;
  logic [NUM_SRC-1:0]                      sync_lvl;
  logic [NUM_SRC-1:0]                      mask_q;
  logic [NUM_SRC-1:0]                      pending_vec;
  logic [NUM_SRC-1:0]                      cand;
  logic [ID_W-1:0]                         id_q, win_id;
  logic                                    win_valid;
  logic                                    i_q;
  logic                                    ack_take;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign ack_take = (state_q == ST_REQ) && INT_ACK;

`ifndef INT_LEVEL_EN
  logic [NUM_SRC-1:0] prev_q, pend_q, rise, ack_vec, clr_vec;

  assign rise    = sync_lvl & ~prev_q;
  assign ack_vec = ack_take ? (NUM_SRC'(1) << id_q) : '0;
  assign clr_vec = PEND_CLR | ack_vec;

  // A fresh edge is OR'd in after clearing so it survives a same-cycle clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= sync_lvl;
      pend_q <= (pend_q & ~clr_vec) | rise;
    end
  end

  assign pending_vec = pend_q;
`else
  logic unused_pend_clr;

  assign unused_pend_clr = ^PEND_CLR;
  assign pending_vec     = sync_lvl;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask_q <= '1;
    end else if (MASK_WE) begin
      mask_q <= MASK_DIN;
    end
  end

  // Clear beats set; taking an interrupt also clears the flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      i_q <= 1'b0;
    end else if (I_CLR || ack_take) begin
      i_q <= 1'b0;
    end else if (I_SET) begin
      i_q <= 1'b1;
    end
  end

  assign cand = i_q ? (pending_vec & mask_q) : '0;

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (INT_ACK)             state_d = ST_SERV;
        else if (I_CLR)          state_d = ST_IDLE;
        else if (!mask_q[id_q])  state_d = ST_IDLE;
      end
      ST_SERV: begin
        if (I_SET && !I_CLR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && win_valid) id_q <= win_id;
    end
  end

  assign INT     = (state_q == ST_REQ);
  assign INT_ID  = id_q;
  assign I_FLAG  = i_q;
  assign PENDING = pending_vec;

endmodule
